note_tracker: RTL

- Streaming pitch tracker that sits after the FFT magnitude stage and in front of the note display/synth logic.
- Per FFT frame, it finds the peak-magnitude bin inside a parametrised analysis window and maps that bin to a note through a run-time-writable lookup table.
- It applies frame-count hysteresis, then publishes a debounced note with on/off and change strobes.

---
 rtl/note_tracker_pkg.sv | 44 ++++
 rtl/note_lut.sv | 54 +++++
 rtl/note_tracker.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/note_tracker_pkg.sv
// Shared types and the power-on note mapping used by the note tracker LUT.
package note_tracker_pkg;

  localparam int NOTE_BITS = 5;
  localparam int CNT_W     = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = 4'd15;

  typedef struct packed {
    logic                 en;
    logic [NOTE_BITS-1:0] note;
  } lut_entry_t;

  // Unvoiced candidate; the note field is forced to zero so equality tests work.
  localparam lut_entry_t SILENCE = '{en: 1'b0, note: '0};

  function automatic lut_entry_t default_note(input int bin);
    lut_entry_t e;
    int n;
    if (bin < 13)       n = -1;
    else if (bin <= 14) n = 0;
    else if (bin <= 23) n = bin - 14;
    else if (bin == 24) n = 9;
    else if (bin <= 26) n = 10;
    else if (bin == 27) n = 11;
    else if (bin <= 29) n = 12;
    else if (bin <= 31) n = 13;
    else if (bin == 32) n = 14;
    else if (bin <= 34) n = 15;
    else if (bin <= 36) n = 16;
    else if (bin <= 38) n = 17;
    else if (bin <= 40) n = 18;
    else if (bin <= 43) n = 19;
    else if (bin <= 45) n = 20;
    else if (bin <= 48) n = 21;
    else if (bin <= 51) n = 22;
    else if (bin <= 54) n = 23;
    else if (bin <= 57) n = 24;
    else                n = -1;
    e.en   = (n >= 0);
    e.note = (n >= 0) ? NOTE_BITS'(n) : '0;
    return e;
  endfunction

endpackage

// File: rtl/note_lut.sv
// Bin-to-note lookup table: one write port, one registered read port, plus the
// live enable bitmap used to qualify samples while a frame accumulates.
module note_lut
  import note_tracker_pkg::*;
#(
  parameter int BIN_W  = 10,
  parameter int BIN_LO = 13,
  parameter int BIN_HI = 57
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [BIN_W-1:0]         waddr,
  input  lut_entry_t               wdata,
  input  logic                     re,
  input  logic [BIN_W-1:0]         raddr,
  output lut_entry_t               rdata,
  output logic [BIN_HI-BIN_LO:0]   en_vec
);

  localparam int DEPTH = BIN_HI - BIN_LO + 1;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [BIN_W-1:0] LO_B = BIN_W'(BIN_LO);
  localparam logic [BIN_W-1:0] HI_B = BIN_W'(BIN_HI);

  function automatic logic in_win(input logic [BIN_W-1:0] b);
    return (b >= LO_B) && (b <= HI_B);
  endfunction

  function automatic logic [IDX_W-1:0] to_idx(input logic [BIN_W-1:0] b);
    return IDX_W'(b - LO_B);
  endfunction

  lut_entry_t mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) mem[k] <= default_note(BIN_LO + k);
    end else if (we && in_win(waddr)) begin
      mem[to_idx(waddr)] <= wdata;
    end
  end

  // Read samples the array before any same-edge write lands.
  always_ff @(posedge clk) begin
    if (re) rdata <= in_win(raddr) ? mem[to_idx(raddr)] : SILENCE;
  end

  always_comb begin
    en_vec = '0;
    for (int k = 0; k < DEPTH; k++) en_vec[k] = mem[k].en;
  end

endmodule

// File: rtl/note_tracker.sv
// Per-frame peak-bin pitch tracker: windowed max search, LUT note lookup and
// frame-count hysteresis producing a debounced note with on/off/change strobes.
module note_tracker
  import note_tracker_pkg::*;
#(
  parameter int BIN_W         = 10,
  parameter int MAG_W         = 16,
  parameter int NOTE_W        = 5,
  parameter int BIN_LO        = 13,
  parameter int BIN_HI        = 57,
  parameter int MAG_THRESH    = 256,
  parameter int STABLE_FRAMES = 3
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  input  logic [BIN_W-1:0]  i_bin,
  input  logic [MAG_W-1:0]  i_mag,
  input  logic              i_last,
  input  logic              i_cfg_we,
  input  logic [BIN_W-1:0]  i_cfg_addr,
  input  logic [NOTE_W:0]   i_cfg_note,
  output logic              o_frame_done,
  output logic [BIN_W-1:0]  o_peak_bin,
  output logic [MAG_W-1:0]  o_peak_mag,
  output logic [NOTE_W-1:0] o_note,
  output logic              o_note_on,
  output logic              o_note_change
);

  localparam int DEPTH = BIN_HI - BIN_LO + 1;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [BIN_W-1:0] LO_B     = BIN_W'(BIN_LO);
  localparam logic [BIN_W-1:0] HI_B     = BIN_W'(BIN_HI);
  localparam logic [MAG_W-1:0] THRESH_C = MAG_W'(MAG_THRESH);
  localparam logic [CNT_W-1:0] STABLE_C = CNT_W'(STABLE_FRAMES);

  function automatic logic in_win(input logic [BIN_W-1:0] b);
    return (b >= LO_B) && (b <= HI_B);
  endfunction

  function automatic logic [IDX_W-1:0] to_idx(input logic [BIN_W-1:0] b);
    return IDX_W'(b - LO_B);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + 1'b1;
  endfunction

  // ---- Stage A: running max over the current frame ----
  logic [BIN_W-1:0] acc_bin_p0;
  logic [MAG_W-1:0] acc_mag_p0;
  logic [DEPTH-1:0] en_vec;
  logic             smp_ok, take, frame_end;
  logic [BIN_W-1:0] fin_bin;
  logic [MAG_W-1:0] fin_mag;

  assign frame_end = i_valid && i_last;

  always_comb begin
    smp_ok = 1'b0;
    if (i_valid && in_win(i_bin)) smp_ok = en_vec[to_idx(i_bin)];
    take    = smp_ok && (i_mag > acc_mag_p0);
    fin_bin = take ? i_bin : acc_bin_p0;
    fin_mag = take ? i_mag : acc_mag_p0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      acc_bin_p0 <= '0;
      acc_mag_p0 <= '0;
    end else if (frame_end) begin
      acc_bin_p0 <= '0;
      acc_mag_p0 <= '0;
    end else if (take) begin
      acc_bin_p0 <= i_bin;
      acc_mag_p0 <= i_mag;
    end
  end

  // ---- Stage B: frame peak registered alongside its LUT read ----
  logic             vld_p1;
  logic [BIN_W-1:0] pk_bin_p1;
  logic [MAG_W-1:0] pk_mag_p1;
  lut_entry_t       lut_rd_p1;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) vld_p1 <= 1'b0;
    else          vld_p1 <= frame_end;
  end

  always_ff @(posedge i_clk) begin
    if (frame_end) begin
      pk_bin_p1 <= fin_bin;
      pk_mag_p1 <= fin_mag;
    end
  end

  note_lut #(
    .BIN_W  (BIN_W),
    .BIN_LO (BIN_LO),
    .BIN_HI (BIN_HI)
  ) u_lut (
    .clk    (i_clk),
    .rst_n  (i_rst_n),
    .we     (i_cfg_we),
    .waddr  (i_cfg_addr),
    .wdata  (lut_entry_t'(i_cfg_note)),
    .re     (frame_end),
    .raddr  (fin_bin),
    .rdata  (lut_rd_p1),
    .en_vec (en_vec)
  );

  // ---- Stage C: hysteresis and commit ----
  lut_entry_t       cand_p1, prev_cand;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             differs, commit;

  always_comb begin
    cand_p1 = SILENCE;
    if ((pk_mag_p1 != '0) && (pk_mag_p1 >= THRESH_C) && lut_rd_p1.en)
      cand_p1 = '{en: 1'b1, note: lut_rd_p1.note};
    cnt_nx  = (cand_p1 == prev_cand) ? sat_inc(cnt) : CNT_W'(1);
    differs = cand_p1.en ? (!o_note_on || (o_note != cand_p1.note)) : o_note_on;
    commit  = vld_p1 && (cnt_nx >= STABLE_C) && differs;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_frame_done  <= 1'b0;
      o_peak_bin    <= '0;
      o_peak_mag    <= '0;
      o_note        <= '0;
      o_note_on     <= 1'b0;
      o_note_change <= 1'b0;
      prev_cand     <= SILENCE;
      cnt           <= '0;
    end else begin
      o_frame_done  <= vld_p1;
      o_note_change <= commit;
      if (vld_p1) begin
        o_peak_bin <= pk_bin_p1;
        o_peak_mag <= pk_mag_p1;
        cnt        <= cnt_nx;
        prev_cand  <= cand_p1;
      end
      if (commit) begin
        o_note_on <= cand_p1.en;
        if (cand_p1.en) o_note <= NOTE_W'(cand_p1.note);
      end
    end
  end

endmodule
